// File: rtl/alu_result_queue.sv
// alu_result_queue
//   Result-capture FIFO between the combinational ALU and the register-file
//   write port. Each accepted ALU result is stored together with its
//   destination index and {Z,V,N,C} flags. It is then presented to writeback
//   through a valid/ready handshake. Sticky overflow/carry status is kept for
//   software-visible exception reporting.
//
//   Optional feature: define ALU_RQ_BYPASS_EN to pass an input straight to the
//   head outputs when the queue is empty and writeback is ready. In that case
//   the entry is not stored.
//
// Parameters
//   DEPTH       FIFO entries (power of two, >= 2)
//   RD_W        destination register index width
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   in_valid    ALU result present           in_ready   queue can accept
//   in_out      ALU result word              in_rd      destination register
//   in_zero/in_ovf/in_neg/in_carry           ALU flags
//   out_valid   head entry valid             out_ready  writeback consumes head
//   out_data    head result                  out_flags  head flags {Z,V,N,C}
//   out_rd      head destination             count      occupied entries
//   status      sticky {V,C}                 status_clr clear sticky status

module alu_result_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned RD_W  = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_out,
    input  logic                       in_zero,
    input  logic                       in_ovf,
    input  logic                       in_neg,
    input  logic                       in_carry,
    input  logic [RD_W-1:0]            in_rd,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_data,
    output logic [3:0]                 out_flags,
    output logic [RD_W-1:0]            out_rd,
    output logic [$clog2(DEPTH):0]     count,
    output logic [1:0]                 status,
    input  logic                       status_clr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [31:0]       data_q  [DEPTH];
    logic [3:0]        flags_q [DEPTH];
    logic [RD_W-1:0]   rd_q    [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [1:0]        status_q, status_d;

    logic              accept;
    logic              bypass;
    logic              push;
    logic              pop;

    // in_ready is held low during reset and is never a function of out_ready.
    assign in_ready = rst_n & (count_q < FULL);
    assign accept   = in_valid & in_ready;

`ifdef ALU_RQ_BYPASS_EN
    assign bypass = accept & out_ready & (count_q == '0) & (in_rd != '0);
`else
    assign bypass = 1'b0;
`endif

    // Entries addressed to register 0 complete the handshake but are dropped.
    assign push = accept & (in_rd != '0) & ~bypass;
    assign pop  = (count_q != '0) & out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // A clear only removes bits that are not being set on the same edge.
    always_comb begin
        status_d = status_clr ? 2'b00 : status_q;
        if (accept) status_d = status_d | {in_ovf, in_carry};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            status_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            status_q <= status_d;
        end
    end

    // Storage needs no reset; the head outputs are gated by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr_q]  <= in_out;
            flags_q[wr_ptr_q] <= {in_zero, in_ovf, in_neg, in_carry};
            rd_q[wr_ptr_q]    <= in_rd;
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_flags = '0;
        out_rd    = '0;
        if (count_q != '0) begin
            out_valid = 1'b1;
            out_data  = data_q[rd_ptr_q];
            out_flags = flags_q[rd_ptr_q];
            out_rd    = rd_q[rd_ptr_q];
        end else if (bypass) begin
            out_valid = 1'b1;
            out_data  = in_out;
            out_flags = {in_zero, in_ovf, in_neg, in_carry};
            out_rd    = in_rd;
        end
    end

    assign count  = count_q;
    assign status = status_q;

endmodule
